// File: rtl/time_keeper_pkg.sv
// Shared types, BCD limits and helpers for the time-of-day / alarm keeper.
package time_keeper_pkg;

  localparam int unsigned BCD_W  = 4;
  localparam int unsigned HHMM_W = 4 * BCD_W;

  localparam logic [2*BCD_W-1:0] MAX_HOUR_BCD = 8'h23;
  localparam logic [2*BCD_W-1:0] MAX_MIN_BCD  = 8'h59;

  typedef struct packed {
    logic [BCD_W-1:0] h10;
    logic [BCD_W-1:0] h1;
    logic [BCD_W-1:0] m10;
    logic [BCD_W-1:0] m1;
  } hhmm_t;

  localparam hhmm_t TIME_RESET  = 16'h0000;
  localparam hhmm_t ALARM_RESET = 16'h0700;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  // Two-digit BCD increment that wraps to 00 after max_v.
  function automatic logic [2*BCD_W-1:0] bcd2_inc(input logic [2*BCD_W-1:0] v,
                                                   input logic [2*BCD_W-1:0] max_v);
    logic [2*BCD_W-1:0] r;
    if (v == max_v) begin
      r = '0;
    end else if (v[BCD_W-1:0] == BCD_W'(9)) begin
      r = {v[2*BCD_W-1:BCD_W] + BCD_W'(1), BCD_W'(0)};
    end else begin
      r = {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] + BCD_W'(1)};
    end
    return r;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_hhmm_counter.sv
// One HH:MM BCD register with run-advance (carrying) and manual (non-carrying) increments.
module time_keeper_bcd_hhmm_counter
  import time_keeper_pkg::*;
#(
  parameter hhmm_t RESET_VAL = TIME_RESET
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Inc_Min_Carry,
  input  logic              i_Inc_Min_NoCarry,
  input  logic              i_Inc_Hour,
  output logic [HHMM_W-1:0] o_Hhmm
);

  hhmm_t              cur;
  hhmm_t              nxt;
  logic [2*BCD_W-1:0] min_bcd;
  logic [2*BCD_W-1:0] hour_bcd;
  logic               min_wrap;
  logic               hour_step;

  // Only the run advance carries a minute wrap into the hours.
  always_comb begin
    nxt       = cur;
    min_bcd   = {cur.m10, cur.m1};
    hour_bcd  = {cur.h10, cur.h1};
    min_wrap  = (min_bcd == MAX_MIN_BCD);
    hour_step = i_Inc_Hour | (i_Inc_Min_Carry & min_wrap);
    if (i_Inc_Min_Carry | i_Inc_Min_NoCarry) begin
      {nxt.m10, nxt.m1} = bcd2_inc(min_bcd, MAX_MIN_BCD);
    end
    if (hour_step) begin
      {nxt.h10, nxt.h1} = bcd2_inc(hour_bcd, MAX_HOUR_BCD);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cur <= RESET_VAL;
    end else begin
      cur <= nxt;
    end
  end

  assign o_Hhmm = cur;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day and alarm setpoint keeper: seconds prescaler, HH:MM run counter and
// button-driven set modes feeding the master controller and display mux.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 25_000_000,
  parameter int unsigned SEC_PER_MIN  = 60
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Change_Time,
  input  logic              i_Change_Alarm,
  input  logic              i_Hours_Inc,
  input  logic              i_Minutes_Inc,
  output logic [HHMM_W-1:0] o_Time,
  output logic [HHMM_W-1:0] o_Alarm_Time,
  output logic              o_Sec_Tick
);

  localparam int unsigned PRE_W = $clog2(CLKS_PER_SEC);
  localparam int unsigned SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

  mode_e            mode;
  logic [PRE_W-1:0] prescaler;
  logic [SEC_W-1:0] seconds;
  logic             hours_prev;
  logic             minutes_prev;
  logic             hours_edge;
  logic             minutes_edge;
  logic             pre_term;
  logic             sec_term;
  logic             run_adv;
  logic             time_set;
  logic             alarm_set;

  // Time-set wins over alarm-set, matching the display-select priority.
  always_comb begin
    mode = MODE_RUN;
    if (i_Change_Time) begin
      mode = MODE_SET_TIME;
    end else if (i_Change_Alarm) begin
      mode = MODE_SET_ALARM;
    end
  end

  always_comb begin
    time_set     = (mode == MODE_SET_TIME);
    alarm_set    = (mode == MODE_SET_ALARM);
    hours_edge   = i_Hours_Inc & ~hours_prev;
    minutes_edge = i_Minutes_Inc & ~minutes_prev;
    pre_term     = (prescaler == PRE_LAST);
    sec_term     = (seconds == SEC_LAST);
    run_adv      = ~time_set & pre_term & sec_term;
  end

  // Edge history runs in every mode so a button held across a mode change never counts.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hours_prev   <= 1'b0;
      minutes_prev <= 1'b0;
    end else begin
      hours_prev   <= i_Hours_Inc;
      minutes_prev <= i_Minutes_Inc;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      prescaler  <= '0;
      seconds    <= '0;
      o_Sec_Tick <= 1'b0;
    end else if (time_set) begin
      prescaler  <= '0;
      seconds    <= '0;
      o_Sec_Tick <= 1'b0;
    end else begin
      o_Sec_Tick <= pre_term;
      if (pre_term) begin
        prescaler <= '0;
        seconds   <= sec_term ? '0 : seconds + SEC_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  time_keeper_bcd_hhmm_counter #(
    .RESET_VAL (TIME_RESET)
  ) u_time (
    .i_Clk             (i_Clk),
    .i_Reset           (i_Reset),
    .i_Inc_Min_Carry   (run_adv),
    .i_Inc_Min_NoCarry (time_set & minutes_edge),
    .i_Inc_Hour        (time_set & hours_edge),
    .o_Hhmm            (o_Time)
  );

  time_keeper_bcd_hhmm_counter #(
    .RESET_VAL (ALARM_RESET)
  ) u_alarm (
    .i_Clk             (i_Clk),
    .i_Reset           (i_Reset),
    .i_Inc_Min_Carry   (1'b0),
    .i_Inc_Min_NoCarry (alarm_set & minutes_edge),
    .i_Inc_Hour        (alarm_set & hours_edge),
    .o_Hhmm            (o_Alarm_Time)
  );

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: minute-of-day model checked every cycle plus hand-computed points.
module tb_time_keeper;

  localparam int unsigned CPS = 4;
  localparam int unsigned SPM = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        ct    = 1'b0;
  logic        ca    = 1'b0;
  logic        hi    = 1'b0;
  logic        mi    = 1'b0;
  logic [15:0] o_time;
  logic [15:0] o_alarm;
  logic        o_tick;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Model state: minutes since midnight, cycles run since last hold, button history.
  int m_time  = 0;
  int m_alarm = 7 * 60;
  int m_run   = 0;
  bit m_tick  = 1'b0;
  bit m_ph    = 1'b0;
  bit m_pm    = 1'b0;

  time_keeper #(
    .CLKS_PER_SEC (CPS),
    .SEC_PER_MIN  (SPM)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Change_Time  (ct),
    .i_Change_Alarm (ca),
    .i_Hours_Inc    (hi),
    .i_Minutes_Inc  (mi),
    .o_Time         (o_time),
    .o_Alarm_Time   (o_alarm),
    .o_Sec_Tick     (o_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int t);
    int hh;
    int mm;
    hh = t / 60;
    mm = t % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  function automatic int bump(input int t, input bit h, input bit m);
    int hh;
    int mm;
    hh = t / 60;
    mm = t % 60;
    if (m) mm = (mm + 1) % 60;
    if (h) hh = (hh + 1) % 24;
    return hh * 60 + mm;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, updated on each active edge.
  initial begin
    bit eh;
    bit em;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_time  = 0;
        m_alarm = 7 * 60;
        m_run   = 0;
        m_tick  = 1'b0;
        m_ph    = 1'b0;
        m_pm    = 1'b0;
      end else begin
        eh   = hi & ~m_ph;
        em   = mi & ~m_pm;
        m_ph = hi;
        m_pm = mi;
        if (ct) begin
          m_run  = 0;
          m_tick = 1'b0;
          m_time = bump(m_time, eh, em);
        end else begin
          m_run  = m_run + 1;
          m_tick = (m_run % CPS) == 0;
          if ((m_run % (CPS * SPM)) == 0) m_time = (m_time + 1) % 1440;
          if (ca) m_alarm = bump(m_alarm, eh, em);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk16("model_time", o_time, to_bcd(m_time));
        chk16("model_alarm", o_alarm, to_bcd(m_alarm));
        chk1("model_tick", o_tick, m_tick);
      end
    end
  end

  task automatic press_h();
    hi = 1'b1;
    @(negedge clk);
    hi = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_m();
    mi = 1'b1;
    @(negedge clk);
    mi = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk16("reset_time", o_time, 16'h0000);
    chk16("reset_alarm", o_alarm, 16'h0700);
    chk1("reset_tick", o_tick, 1'b0);
    checking = 1'b1;
    rst = 1'b0;

    // Free run: ticks on clocks 4 and 8, one minute after 8 clocks.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk1("run_tick", o_tick, logic'(i == 4 || i == 8));
    end
    chk16("run_1min", o_time, 16'h0001);

    // Preload 23:59 then let it roll over.
    ct = 1'b1;
    repeat (23) press_h();
    repeat (58) press_m();
    chk16("preload_2359", o_time, 16'h2359);
    ct = 1'b0;
    repeat (8) @(negedge clk);
    chk16("rollover_0000", o_time, 16'h0000);

    // Held minute button counts once; manual minute wraps without carry.
    ct = 1'b1;
    @(negedge clk);
    mi = 1'b1;
    repeat (10) @(negedge clk);
    mi = 1'b0;
    @(negedge clk);
    chk16("held_once", o_time, 16'h0001);
    repeat (9) press_h();
    repeat (58) press_m();
    chk16("preload_0959", o_time, 16'h0959);
    press_m();
    chk16("min_nocarry", o_time, 16'h0900);

    // Alarm set: simultaneous edges, time keeps running, hour wrap.
    ct = 1'b0;
    ca = 1'b1;
    hi = 1'b1;
    mi = 1'b1;
    @(negedge clk);
    hi = 1'b0;
    mi = 1'b0;
    chk16("alarm_both", o_alarm, 16'h0801);
    repeat (7) @(negedge clk);
    chk16("alarm_time_runs", o_time, 16'h0901);
    repeat (15) press_h();
    chk16("alarm_2301", o_alarm, 16'h2301);
    press_h();
    chk16("alarm_hour_wrap", o_alarm, 16'h0001);
    chk16("time_0905", o_time, 16'h0905);

    // Both modes requested: time-set wins.
    ct = 1'b1;
    press_h();
    chk16("prio_time", o_time, 16'h1005);
    chk16("prio_alarm_same", o_alarm, 16'h0001);
    ct = 1'b0;
    ca = 1'b0;
    mi = 1'b1;
    repeat (2) @(negedge clk);
    ct = 1'b1;
    repeat (4) @(negedge clk);
    mi = 1'b0;
    @(negedge clk);
    chk16("held_on_entry", o_time, 16'h1005);

    // Asynchronous reset between edges while in alarm-set.
    ct = 1'b0;
    ca = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk16("async_rst_time", o_time, 16'h0000);
    chk16("async_rst_alarm", o_alarm, 16'h0700);
    chk1("async_rst_tick", o_tick, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk16("post_rst_time", o_time, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
